// File: rtl/controlador.sv
// controlador: microprogrammed coffee-machine sequencer driving eight one-hot stage outputs.
// Optional macro CONTROLADOR_INPUT_SYNC_EN adds a 2-flop synchronizer on every Condicion input.
module controlador (
    input  logic clk,
    input  logic rst,
    input  logic Condicion1,
    input  logic Condicion2,
    input  logic Condicion3,
    input  logic Condicion4,
    input  logic Condicion5,
    input  logic Condicion6,
    output logic salida0,
    output logic salida1,
    output logic salida2,
    output logic salida3,
    output logic salida4,
    output logic salida5,
    output logic salida6,
    output logic salida7
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WATER_CHECK = 3'd1,
        SELECT_A    = 3'd2,
        SELECT_B    = 3'd3,
        COFFEE      = 3'd4,
        TEA         = 3'd5,
        DISPENSE    = 3'd6,
        FAULT       = 3'd7
    } upc_e;

    typedef struct packed {
        logic [7:0] out;
        logic [2:0] csel;
        logic       pol;
        logic [2:0] addr_t;
        logic [2:0] addr_f;
    } uword_t;

    // csel 0 means unconditional; 1..6 pick Condicion1..6 (all active-low, so pol is 0)
    function automatic uword_t rom(input upc_e a);
        case (a)
            IDLE:        rom = '{8'h01, 3'd1, 1'b0, 3'd1, 3'd0};
            WATER_CHECK: rom = '{8'h02, 3'd2, 1'b0, 3'd2, 3'd7};
            SELECT_A:    rom = '{8'h04, 3'd3, 1'b0, 3'd4, 3'd3};
            SELECT_B:    rom = '{8'h08, 3'd4, 1'b0, 3'd5, 3'd2};
            COFFEE:      rom = '{8'h10, 3'd5, 1'b0, 3'd6, 3'd7};
            TEA:         rom = '{8'h20, 3'd0, 1'b0, 3'd6, 3'd6};
            DISPENSE:    rom = '{8'h40, 3'd6, 1'b0, 3'd0, 3'd6};
            default:     rom = '{8'h80, 3'd2, 1'b0, 3'd0, 3'd7};
        endcase
    endfunction

    logic [5:0] cond_raw;
    logic [5:0] cond_s;
    uword_t     word;
    logic       cond_hit;
    upc_e       upc_q, upc_d;

    assign cond_raw = {Condicion6, Condicion5, Condicion4, Condicion3, Condicion2, Condicion1};

`ifdef CONTROLADOR_INPUT_SYNC_EN
    logic [5:0] sync1_q, sync1_d;
    logic [5:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = cond_raw;
        sync2_d = sync1_q;
    end

    // Reset to all-ones so no condition looks asserted while the chain fills
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 6'h3f;
            sync2_q <= 6'h3f;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign cond_s = sync2_q;
`else
    assign cond_s = cond_raw;
`endif

    always_comb begin
        word     = rom(upc_q);
        cond_hit = 1'b1;
        case (word.csel)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6:
                cond_hit = (cond_s[word.csel - 3'd1] == word.pol);
            default:
                cond_hit = 1'b1;
        endcase
        upc_d = cond_hit ? upc_e'(word.addr_t) : upc_e'(word.addr_f);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) upc_q <= IDLE;
        else     upc_q <= upc_d;
    end

    assign {salida7, salida6, salida5, salida4, salida3, salida2, salida1, salida0} = word.out;

endmodule

// File: tb/tb_controlador.sv
// tb_controlador: directed-vector bench for the coffee-machine microsequencer (default build, no input sync).
module tb_controlador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:1] cnd = 6'b111111;
    logic       salida0, salida1, salida2, salida3, salida4, salida5, salida6, salida7;
    logic [7:0] sal;
    int         n_checks = 0;
    int         n_fail   = 0;

    controlador dut (
        .clk        (clk),
        .rst        (rst),
        .Condicion1 (cnd[1]),
        .Condicion2 (cnd[2]),
        .Condicion3 (cnd[3]),
        .Condicion4 (cnd[4]),
        .Condicion5 (cnd[5]),
        .Condicion6 (cnd[6]),
        .salida0    (salida0),
        .salida1    (salida1),
        .salida2    (salida2),
        .salida3    (salida3),
        .salida4    (salida4),
        .salida5    (salida5),
        .salida6    (salida6),
        .salida7    (salida7)
    );

    assign sal = {salida7, salida6, salida5, salida4, salida3, salida2, salida1, salida0};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cnd = 6'b111111;
        rst = 1'b1;
        #3;
        n_checks++;
        if (sal !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_async: salida=%b expected %b", sal, 8'h01);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (sal !== 8'h01) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: salida=%b expected %b", i, sal, 8'h01);
            end
        end
    endtask

    // vectors are {C6,C5,C4,C3,C2,C1}, applied just after an edge and sampled on the next
    task automatic test_coffee();
        logic [6:1] cv [7];
        logic [7:0] ev [7];
        cv = '{6'b111100, 6'b111101, 6'b101001, 6'b101001, 6'b101111, 6'b011111, 6'b111111};
        ev = '{8'h02, 8'h04, 8'h10, 8'h40, 8'h40, 8'h01, 8'h01};
        for (int i = 0; i < 7; i++) begin
            cnd = cv[i];
            step();
            n_checks++;
            if (sal !== ev[i]) begin
                n_fail++;
                $display("FAIL coffee step %0d: salida=%b expected %b", i, sal, ev[i]);
            end
        end
    endtask

    task automatic test_tea();
        logic [6:1] cv [9];
        logic [7:0] ev [9];
        cv = '{6'b111100, 6'b111101, 6'b110111, 6'b110111, 6'b111111,
               6'b111111, 6'b111111, 6'b011111, 6'b111111};
        ev = '{8'h02, 8'h04, 8'h08, 8'h20, 8'h40, 8'h40, 8'h40, 8'h01, 8'h01};
        for (int i = 0; i < 9; i++) begin
            cnd = cv[i];
            step();
            n_checks++;
            if (sal !== ev[i]) begin
                n_fail++;
                $display("FAIL tea step %0d: salida=%b expected %b", i, sal, ev[i]);
            end
        end
    endtask

    task automatic test_faults();
        logic [6:1] cv [11];
        logic [7:0] ev [11];
        cv = '{6'b111110, 6'b111111, 6'b111111, 6'b111101, 6'b111111,
               6'b111100, 6'b111101, 6'b111001, 6'b111001, 6'b111101, 6'b111111};
        ev = '{8'h02, 8'h80, 8'h80, 8'h01, 8'h01,
               8'h02, 8'h04, 8'h10, 8'h80, 8'h01, 8'h01};
        for (int i = 0; i < 11; i++) begin
            cnd = cv[i];
            step();
            n_checks++;
            if (sal !== ev[i]) begin
                n_fail++;
                $display("FAIL fault step %0d: salida=%b expected %b", i, sal, ev[i]);
            end
        end
    endtask

    // alternation with no button, then both buttons pressed in SELECT_A and in SELECT_B
    task automatic test_no_select();
        logic [6:1] cv [15];
        logic [7:0] ev [15];
        cv = '{6'b111100, 6'b111101, 6'b111111, 6'b111111, 6'b111111, 6'b111111,
               6'b110011, 6'b100111, 6'b011111,
               6'b111100, 6'b111101, 6'b111111, 6'b110011, 6'b111111, 6'b011111};
        ev = '{8'h02, 8'h04, 8'h08, 8'h04, 8'h08, 8'h04,
               8'h10, 8'h40, 8'h01,
               8'h02, 8'h04, 8'h08, 8'h20, 8'h40, 8'h01};
        for (int i = 0; i < 15; i++) begin
            cnd = cv[i];
            step();
            n_checks++;
            if (sal !== ev[i]) begin
                n_fail++;
                $display("FAIL no_select step %0d: salida=%b expected %b", i, sal, ev[i]);
            end
        end
        cnd = 6'b111111;
    endtask

    task automatic test_reset_mid();
        logic [6:1] cv [4];
        cv = '{6'b111100, 6'b111101, 6'b101001, 6'b101001};
        for (int i = 0; i < 4; i++) begin
            cnd = cv[i];
            step();
        end
        cnd = 6'b101111;
        n_checks++;
        if (sal !== 8'h40) begin
            n_fail++;
            $display("FAIL mid_reset_pre: salida=%b expected %b", sal, 8'h40);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (sal !== 8'h01) begin
            n_fail++;
            $display("FAIL mid_reset_async: salida=%b expected %b", sal, 8'h01);
        end
        #2 rst = 1'b0;
        cnd = 6'b111111;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (sal !== 8'h01) begin
                n_fail++;
                $display("FAIL mid_reset_after cycle %0d: salida=%b expected %b", i, sal, 8'h01);
            end
        end
    endtask

    initial begin
        test_reset();
        test_coffee();
        test_tea();
        test_faults();
        test_no_select();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
